// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch queue: instruction/address widths,
// FSM encoding and the queue entry layout.
package fetch_pkg;

  typedef logic [15:0] instr_t;
  typedef logic [7:0]  addr_t;

  localparam instr_t NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} fq_state_t;

  typedef struct packed {
    instr_t instr;
    addr_t  pc;
  } fq_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// Circular buffer of fetched {instr, pc} entries with synchronous clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module fq_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  fq_entry_t              wdata,
  output fq_entry_t              rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  fq_entry_t     mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues imem requests under a credit limit, queues
// in-order responses, squashes wrong-path data after a redirect. Option: FETCHQ_BYPASS_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter int    MAX_OUT  = 2,
  parameter addr_t PC_STEP  = 8'd4,
  parameter addr_t RESET_PC = 8'h00
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   StallF,
  input  logic   RedirectE,
  input  addr_t  RedirectPCE,
  output logic   imem_req,
  output addr_t  imem_addr,
  input  logic   imem_gnt,
  input  logic   imem_rvalid,
  input  instr_t imem_rdata,
  output instr_t InstrF,
  output addr_t  PCF,
  output logic   InstrValidF
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUT);
  localparam logic [CW-1:0] ONE     = CW'(1);

  fq_state_t     state;
  fq_state_t     state_nxt;
  addr_t         fetch_pc;
  addr_t         rsp_pc;
  addr_t         pcf_hold;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_nxt;
  logic [CW-1:0] stale;
  logic [CW-1:0] stale_nxt;
  logic [CW-1:0] count;
  logic          issue;
  logic          rsp_live;
  logic          bypass;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  fq_entry_t     head;

  assign imem_addr = fetch_pc;
  assign issue     = imem_req & imem_gnt;
  assign rsp_live  = imem_rvalid & (stale == '0);

`ifdef FETCHQ_BYPASS_EN
  assign bypass = empty & rsp_live & ~StallF & ~RedirectE;
`else
  assign bypass = 1'b0;
`endif

  // A redirect wins over everything: no push or pop in that cycle.
  assign push = rsp_live & ~RedirectE & ~bypass;
  assign pop  = ~empty & ~StallF & ~RedirectE;

  always_comb begin
    out_nxt = outstanding;
    if (issue && !imem_rvalid)      out_nxt = outstanding + ONE;
    else if (!issue && imem_rvalid) out_nxt = outstanding - ONE;
  end

  // Everything still in flight after this cycle's accounting belongs to the old path.
  always_comb begin
    stale_nxt = stale;
    if (RedirectE)                        stale_nxt = out_nxt;
    else if (imem_rvalid && stale != '0)  stale_nxt = stale - ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      IDLE:  state_nxt = RUN;
      RUN:   if (RedirectE && stale_nxt != '0) state_nxt = DRAIN;
      DRAIN: if (stale_nxt == '0) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE)
      imem_req = (({1'b0, count} + {1'b0, outstanding}) < DEPTH_C) && (outstanding < MAXO_C);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      pcf_hold    <= 8'h00;
      outstanding <= '0;
      stale       <= '0;
    end else begin
      outstanding <= out_nxt;
      stale       <= stale_nxt;
      pcf_hold    <= PCF;
      if (RedirectE)  fetch_pc <= RedirectPCE;
      else if (issue) fetch_pc <= fetch_pc + PC_STEP;
      // Live responses arrive in issue order, so their PC is a running counter.
      if (RedirectE)     rsp_pc <= RedirectPCE;
      else if (rsp_live) rsp_pc <= rsp_pc + PC_STEP;
    end
  end

  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (RedirectE),
    .wdata ('{instr: imem_rdata, pc: rsp_pc}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    InstrValidF = ~empty;
    InstrF      = head.instr;
    PCF         = head.pc;
    if (bypass) begin
      InstrValidF = 1'b1;
      InstrF      = imem_rdata;
      PCF         = rsp_pc;
    end else if (empty) begin
      InstrF = NOP_INSTR;
      PCF    = pcf_hold;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && full));
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: memory model with variable latency, scoreboard of
// expected {pc, instr}, a startup vector table and hand-written corner sequences.
module tb_fetch_queue;
  import fetch_pkg::*;

  logic   clk = 1'b0;
  logic   reset, StallF, RedirectE, imem_req, imem_gnt, imem_rvalid, InstrValidF;
  addr_t  RedirectPCE, imem_addr, PCF;
  instr_t imem_rdata, InstrF;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk(clk), .reset(reset), .StallF(StallF), .RedirectE(RedirectE),
    .RedirectPCE(RedirectPCE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrF(InstrF), .PCF(PCF), .InstrValidF(InstrValidF)
  );

  typedef struct { addr_t addr; int due; bit stale; } flight_t;
  typedef struct packed { addr_t pc; instr_t instr; } sb_t;
  typedef struct { bit req; addr_t addr; bit valid; addr_t pc; instr_t instr; } vec_t;

  flight_t inflight[$];
  sb_t     sb[$];
  vec_t    tbl[8];
  int      total = 0, bad = 0, cyc = 0, lat = 1;
  bit      started = 0, gnt_en = 1;
  addr_t   exp_pc = 8'h00, last_pc = 8'h00;
  bit      s_req, s_valid;
  addr_t   s_addr, s_pc;
  instr_t  s_instr;

  function automatic instr_t mem_word(addr_t a);
    return {a ^ 8'h5A, ~a};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, then advance the model to the next posedge.
  task automatic cycle(bit stall, bit redir, addr_t tgt);
    bit rv, live, exp_req, exp_valid;
    int pre_size;
    flight_t f;
    sb_t e;
    @(negedge clk);
    rv = (inflight.size() > 0) && (cyc >= inflight[0].due);
    StallF = stall; RedirectE = redir; RedirectPCE = tgt; imem_gnt = gnt_en;
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(inflight[0].addr) : 16'($urandom);
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = InstrValidF; s_pc = PCF; s_instr = InstrF;
    exp_req = started && (sb.size() + inflight.size() < 4) && (inflight.size() < 2);
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, exp_pc);
    pre_size = sb.size();
    live = 0;
    if (rv) begin
      f = inflight.pop_front();
      live = !f.stale && !redir;
      if (live) sb.push_back('{pc: f.addr, instr: mem_word(f.addr)});
    end
    exp_valid = (pre_size > 0);
`ifdef FETCHQ_BYPASS_EN
    if (pre_size == 0 && live && !stall) exp_valid = 1;
`endif
    check("InstrValidF", InstrValidF, exp_valid);
    if (exp_valid) begin
      e = sb[0];
      check("PCF", PCF, e.pc);
      check("InstrF", InstrF, e.instr);
      last_pc = e.pc;
      if (!stall && !redir) void'(sb.pop_front());
    end else begin
      check("InstrF_nop", InstrF, NOP_INSTR);
      check("PCF_hold", PCF, last_pc);
    end
    if (exp_req && gnt_en) begin
      inflight.push_back('{addr: exp_pc, due: cyc + lat, stale: redir});
      exp_pc = exp_pc + 8'd4;
    end
    if (redir) begin
      foreach (inflight[i]) inflight[i].stale = 1;
      sb.delete();
      exp_pc = tgt;
    end
    started = 1;
    cyc++;
  endtask

  task automatic model_reset();
    inflight.delete(); sb.delete();
    exp_pc = 8'h00; last_pc = 8'h00; started = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat_v, n, k;
    addr_t got[3];
    addr_t want[3];
    bit ok;

`ifdef FETCHQ_BYPASS_EN
    lat_v = 2;
`else
    lat_v = 3;
`endif
    for (int i = 0; i < 8; i++) begin
      tbl[i].req   = (i >= 1);
      tbl[i].addr  = (i >= 1) ? 8'((i - 1) * 4) : 8'h00;
      tbl[i].valid = (i >= lat_v);
      tbl[i].pc    = (i >= lat_v) ? 8'((i - lat_v) * 4) : 8'h00;
      tbl[i].instr = (i >= lat_v) ? mem_word(tbl[i].pc) : NOP_INSTR;
    end
    want[0] = 8'hF8; want[1] = 8'hFC; want[2] = 8'h00;

    // Reset state
    reset = 1; StallF = 0; RedirectE = 0; RedirectPCE = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    model_reset();
    #2;
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", InstrValidF, 1'b0);
    check("rst_instr", InstrF, NOP_INSTR);
    check("rst_pcf", PCF, 8'h00);
    repeat (2) @(posedge clk);
    #2 reset = 0;

    // Startup vectors: zero-wait memory, no stall
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 8'h00);
      check("tbl_req", s_req, tbl[i].req);
      if (tbl[i].req) check("tbl_addr", s_addr, tbl[i].addr);
      check("tbl_valid", s_valid, tbl[i].valid);
      check("tbl_pc", s_pc, tbl[i].pc);
      check("tbl_instr", s_instr, tbl[i].instr);
    end
    repeat (4) cycle(0, 0, 8'h00);

    // Stall: queue fills, request drops at the credit limit, then resumes
    repeat (6) cycle(1, 0, 8'h00);
    repeat (10) cycle(0, 0, 8'h00);

    // Grant withheld, then slow memory
    gnt_en = 0;
    repeat (5) cycle(0, 0, 8'h00);
    gnt_en = 1; lat = 3;
    repeat (20) cycle(0, 0, 8'h00);

    // Redirect with two requests in flight
    n = 0;
    while (inflight.size() != 2 && n < 20) begin cycle(0, 0, 8'h00); n++; end
    check("two_in_flight_reached", (inflight.size() == 2), 1'b1);
    cycle(0, 1, 8'h40);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cycle(0, 0, 8'h00);
      if (s_valid) begin check("first_pc_after_redirect", s_pc, 8'h40); ok = 1; end
    end
    if (!ok) check("redirect_valid_timeout", 0, 1);

    // Redirect coinciding with an rvalid and a pop
    lat = 1;
    repeat (8) cycle(0, 0, 8'h00);
    check("steady_valid", s_valid, 1'b1);
    cycle(0, 1, 8'h80);
    cycle(0, 0, 8'h00);
    check("redir_queue_empty", s_valid, 1'b0);
    repeat (8) cycle(0, 0, 8'h00);

    // Fetch address wraps past 8'hFC
    cycle(0, 1, 8'hF8);
    k = 0;
    for (int i = 0; i < 10 && k < 3; i++) begin
      cycle(0, 0, 8'h00);
      if (s_req) begin got[k] = s_addr; k++; end
    end
    check("wrap_issue_count", k, 3);
    for (int i = 0; i < k; i++) check("wrap_addr", got[i], want[i]);
    repeat (4) cycle(0, 0, 8'h00);

    // Asynchronous reset between clock edges
    #2 reset = 1;
    #1;
    check("async_req", imem_req, 1'b0);
    check("async_valid", InstrValidF, 1'b0);
    check("async_instr", InstrF, NOP_INSTR);
    check("async_pcf", PCF, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 0;
    repeat (3) cycle(0, 0, 8'h00);
    check("restart_addr", s_addr, 8'h04);
    repeat (8) cycle(0, 0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
